// File: rtl/sparse_fold_loader_pkg.sv
// Shared definitions for the sparse fold loader: FSM encoding and small helpers.
package sparse_fold_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT_DONE,
    S_CLEANUP
  } state_t;

  // Fold numbers stop at the top of their range instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/sparse_fold_loader_if.sv
// Bitmap/element handshakes and fold outputs of the sparse fold loader.
interface sparse_fold_loader_if #(
  parameter int ROWS      = 4,
  parameter int COLS      = 8,
  parameter int LOG2_ROWS = 2,
  parameter int LOG2_COLS = 3,
  parameter int NUM_PES   = 32,
  parameter int LOG2_PES  = 5,
  parameter int DATA_TYPE = 32
);
  logic                           bm_valid;
  logic                           bm_ready;
  logic [ROWS*COLS-1:0]           bit_map;
  logic                           ele_valid;
  logic                           ele_ready;
  logic [DATA_TYPE-1:0]           ele_data;
  logic                           done_computing_one_tile;
  logic                           fold_valid;
  logic [LOG2_PES:0]              fold_count;
  logic [15:0]                    fold_idx;
  logic [NUM_PES-1:0]             pe_mask;
  logic [NUM_PES*DATA_TYPE-1:0]   stationary_buffer;
  logic [NUM_PES*LOG2_ROWS-1:0]   pe_row;
  logic [NUM_PES*LOG2_COLS-1:0]   pe_col;
  logic                           tile_done;

  // Operand front end / consumer side.
  modport master (
    output bm_valid, bit_map, ele_valid, ele_data, done_computing_one_tile,
    input  bm_ready, ele_ready, fold_valid, fold_count, fold_idx, pe_mask,
           stationary_buffer, pe_row, pe_col, tile_done
  );

  // Loader side.
  modport slave (
    input  bm_valid, bit_map, ele_valid, ele_data, done_computing_one_tile,
    output bm_ready, ele_ready, fold_valid, fold_count, fold_idx, pe_mask,
           stationary_buffer, pe_row, pe_col, tile_done
  );
endinterface

// File: rtl/sparse_pri_enc.sv
// Lowest-set-bit encoder: index of the first nonzero in scan order.
module sparse_pri_enc #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 5
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] index,
  output logic             any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    index = '0;
    any   = |vec;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) index = IDX_W'(i);
    end
  end

endmodule

// File: rtl/sparse_fold_loader.sv
// Packs a tile's nonzero stream into NUM_PES stationary slots, one fold at a time.
module sparse_fold_loader
  import sparse_fold_loader_pkg::*;
#(
  parameter int ROWS      = 4,
  parameter int COLS      = 8,
  parameter int LOG2_ROWS = 2,
  parameter int LOG2_COLS = 3,
  parameter int NUM_PES   = 32,
  parameter int LOG2_PES  = 5,
  parameter int DATA_TYPE = 32
) (
  input logic               clk,
  input logic               rst,
  sparse_fold_loader_if.slave bus
);

  localparam int BITS  = ROWS * COLS;
  localparam int IDX_W = LOG2_ROWS + LOG2_COLS;
  localparam logic [LOG2_PES:0] LAST_CNT = (LOG2_PES + 1)'(NUM_PES - 1);

  state_t state_q, state_d;

  logic [BITS-1:0]                         work_bm_q;
  logic [LOG2_PES:0]                       cnt_q;
  logic [15:0]                             fold_idx_q;
  logic [NUM_PES-1:0]                      mask_q;
  logic [NUM_PES-1:0][DATA_TYPE-1:0]       slot_q;
  logic [NUM_PES-1:0][LOG2_ROWS-1:0]       row_q;
  logic [NUM_PES-1:0][LOG2_COLS-1:0]       col_q;

  logic [IDX_W-1:0] pos;
  logic             bm_any;
  logic [BITS-1:0]  pos_onehot;
  logic             last_slot, last_bit;
  logic             bm_hs, ele_hs, next_fold, clear_fold;
  logic             bm_ready, ele_ready, fold_valid, tile_done;

  sparse_pri_enc #(.WIDTH(BITS), .IDX_W(IDX_W)) u_pri_enc (
    .vec   (work_bm_q),
    .index (pos),
    .any   (bm_any)
  );

  assign pos_onehot = BITS'(1) << pos;
  assign last_slot  = (cnt_q == LAST_CNT);
  assign last_bit   = ((work_bm_q & ~pos_onehot) == '0);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic plus handshake and status decode.
  always_comb begin
    state_d    = state_q;
    bm_ready   = 1'b0;
    ele_ready  = 1'b0;
    fold_valid = 1'b0;
    tile_done  = 1'b0;
    bm_hs      = 1'b0;
    ele_hs     = 1'b0;
    next_fold  = 1'b0;
    clear_fold = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        bm_ready = 1'b1;
        bm_hs    = bus.bm_valid;
        if (bus.bm_valid) state_d = (bus.bit_map == '0) ? S_CLEANUP : S_LOAD;
      end
      S_LOAD: begin
        ele_ready = bm_any;
        ele_hs    = bus.ele_valid && bm_any;
        if (ele_hs && (last_slot || last_bit)) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        fold_valid = 1'b1;
        state_d    = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        fold_valid = 1'b1;
        if (bus.done_computing_one_tile) begin
          next_fold  = bm_any;
          clear_fold = bm_any;
          state_d    = bm_any ? S_LOAD : S_CLEANUP;
        end
      end
      S_CLEANUP: begin
        tile_done  = 1'b1;
        clear_fold = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Working bitmap, slot fill and fold bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: slot storage is reset because unused slots must read zero from the first cycle.
      work_bm_q  <= '0;
      cnt_q      <= '0;
      fold_idx_q <= '0;
      mask_q     <= '0;
      slot_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
    end else begin
      if (bm_hs) begin
        work_bm_q  <= bus.bit_map;
        fold_idx_q <= '0;
      end
      if (ele_hs) begin
        slot_q[cnt_q[LOG2_PES-1:0]] <= bus.ele_data;
        row_q[cnt_q[LOG2_PES-1:0]]  <= pos[IDX_W-1:LOG2_COLS];
        col_q[cnt_q[LOG2_PES-1:0]]  <= pos[LOG2_COLS-1:0];
        mask_q[cnt_q[LOG2_PES-1:0]] <= 1'b1;
        work_bm_q                   <= work_bm_q & ~pos_onehot;
        cnt_q                       <= cnt_q + 1'b1;
      end
      if (clear_fold) begin
        cnt_q  <= '0;
        mask_q <= '0;
        slot_q <= '0;
        row_q  <= '0;
        col_q  <= '0;
      end
      if (next_fold) fold_idx_q <= sat_inc16(fold_idx_q);
    end
  end

  assign bus.bm_ready          = bm_ready;
  assign bus.ele_ready         = ele_ready;
  assign bus.fold_valid        = fold_valid;
  assign bus.tile_done         = tile_done;
  assign bus.fold_count        = cnt_q;
  assign bus.fold_idx          = fold_idx_q;
  assign bus.pe_mask           = mask_q;
  assign bus.stationary_buffer = slot_q;
  assign bus.pe_row            = row_q;
  assign bus.pe_col            = col_q;

endmodule

// File: tb/tb_sparse_fold_loader.sv
// Scoreboard bench: a 32-slot loader and an 8-slot loader driven from shared stimulus.
module tb_sparse_fold_loader;

  typedef struct packed {
    logic [5:0]        count;
    logic [15:0]       idx;
    logic [31:0]       mask;
    logic [31:0][31:0] data;
    logic [31:0][1:0]  row;
    logic [31:0][2:0]  col;
  } fold_t;

  localparam logic [31:0] T1_BM = 32'hACA4_006C;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        bm_valid = 1'b0, ele_valid = 1'b0, done = 1'b0;
  logic [31:0] bit_map = '0, ele_data = '0;

  sparse_fold_loader_if #(.NUM_PES(32), .LOG2_PES(5)) if_a ();
  sparse_fold_loader_if #(.NUM_PES(8),  .LOG2_PES(3)) if_b ();

  assign if_a.bm_valid  = bm_valid  && !sel;
  assign if_b.bm_valid  = bm_valid  &&  sel;
  assign if_a.ele_valid = ele_valid && !sel;
  assign if_b.ele_valid = ele_valid &&  sel;
  assign if_a.done_computing_one_tile = done && !sel;
  assign if_b.done_computing_one_tile = done &&  sel;
  assign if_a.bit_map  = bit_map;
  assign if_b.bit_map  = bit_map;
  assign if_a.ele_data = ele_data;
  assign if_b.ele_data = ele_data;

  sparse_fold_loader #(.NUM_PES(32), .LOG2_PES(5)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  sparse_fold_loader #(.NUM_PES(8),  .LOG2_PES(3)) dut_b (.clk(clk), .rst(rst), .bus(if_b));

  int checks = 0;
  int failures = 0;

  fold_t       qa[$];
  fold_t       qb[$];
  logic [1:0]  crow[32];
  logic [2:0]  ccol[32];
  logic [31:0] dat[32];

  logic          prev_v[2];
  logic          chg[2];
  logic [1237:0] snap[2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic cur_bm_ready();   return sel ? if_b.bm_ready   : if_a.bm_ready;   endfunction
  function automatic logic cur_ele_ready();  return sel ? if_b.ele_ready  : if_a.ele_ready;  endfunction
  function automatic logic cur_fold_valid(); return sel ? if_b.fold_valid : if_a.fold_valid; endfunction
  function automatic logic cur_tile_done();  return sel ? if_b.tile_done  : if_a.tile_done;  endfunction

  // Expected fold: slots first..first+count-1 of the current coordinate/data tables.
  task automatic push_fold(input int id, input int first, input int count, input int idx);
    fold_t f;
    f       = '0;
    f.count = 6'(count);
    f.idx   = 16'(idx);
    for (int k = 0; k < count; k++) begin
      f.mask[k] = 1'b1;
      f.data[k] = dat[first + k];
      f.row[k]  = crow[first + k];
      f.col[k]  = ccol[first + k];
    end
    if (id == 0) qa.push_back(f);
    else         qb.push_back(f);
  endtask

  // Monitor step for one DUT: compare on fold_valid rise, track stability while it stays high.
  task automatic mon_step(input int id, input logic fv, input logic [5:0] cnt, input logic [15:0] idx,
                          input logic [31:0] mask, input logic [1023:0] sbuf, input logic [63:0] rows,
                          input logic [95:0] cols, input int npes);
    logic [1237:0] cur;
    fold_t         f;
    int            qn;
    cur = {sbuf, rows, cols, mask, cnt, idx};
    if (fv && !prev_v[id]) begin
      qn = (id == 0) ? qa.size() : qb.size();
      check($sformatf("fold_expected_dut%0d", id), 64'(qn > 0), 64'd1);
      if (qn > 0) begin
        if (id == 0) f = qa.pop_front();
        else         f = qb.pop_front();
        check($sformatf("fold_count_dut%0d", id), 64'(cnt), 64'(f.count));
        check($sformatf("fold_idx_dut%0d", id), 64'(idx), 64'(f.idx));
        check($sformatf("pe_mask_dut%0d", id), 64'(mask), 64'(f.mask));
        for (int k = 0; k < npes; k++) begin
          check($sformatf("slot%0d_data_dut%0d", k, id), 64'(sbuf[k*32 +: 32]), 64'(f.data[k]));
          check($sformatf("slot%0d_coord_dut%0d", k, id),
                64'({rows[k*2 +: 2], cols[k*3 +: 3]}), 64'({f.row[k], f.col[k]}));
        end
      end
      snap[id] = cur;
      chg[id]  = 1'b0;
    end else if (fv && prev_v[id] && (cur !== snap[id])) begin
      chg[id] = 1'b1;
    end
    if (!fv && prev_v[id]) check($sformatf("fold_hold_stable_dut%0d", id), 64'(chg[id]), 64'd0);
    prev_v[id] = fv;
  endtask

  // Monitor process, sampling on the falling edge.
  initial begin
    prev_v = '{1'b0, 1'b0};
    chg    = '{1'b0, 1'b0};
    forever begin
      @(negedge clk);
      mon_step(0, if_a.fold_valid, if_a.fold_count, if_a.fold_idx, if_a.pe_mask,
               if_a.stationary_buffer, if_a.pe_row, if_a.pe_col, 32);
      mon_step(1, if_b.fold_valid, 6'(if_b.fold_count), if_b.fold_idx, 32'(if_b.pe_mask),
               1024'(if_b.stationary_buffer), 64'(if_b.pe_row), 96'(if_b.pe_col), 8);
    end
  end

  // All drive tasks start and end at the drive point, 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bm(input logic [31:0] bm);
    int g = 0;
    while (!cur_bm_ready() && g < 100) begin step(); g++; end
    check("bm_ready_wait", 64'(cur_bm_ready()), 64'd1);
    bm_valid = 1'b1;
    bit_map  = bm;
    step();
    bm_valid = 1'b0;
    if (bm != '0) begin
      check("bm_to_ele_ready", 64'(cur_ele_ready()), 64'd1);
    end else begin
      check("zero_bm_tile_done", 64'(cur_tile_done()), 64'd1);
      check("zero_bm_ele_ready", 64'(cur_ele_ready()), 64'd0);
      check("zero_bm_fold_valid", 64'(cur_fold_valid()), 64'd0);
      step();
      check("zero_bm_tile_done_end", 64'(cur_tile_done()), 64'd0);
      check("zero_bm_bm_ready", 64'(cur_bm_ready()), 64'd1);
    end
  endtask

  task automatic send_elems(input int first, input int n, input bit rnd);
    for (int i = first; i < first + n; i++) begin
      int   g   = 0;
      logic acc = 1'b0;
      while (!acc && g < 100) begin
        ele_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        ele_data  = dat[i];
        acc       = ele_valid && cur_ele_ready();
        step();
        g++;
      end
      ele_valid = 1'b0;
      if (!acc) check($sformatf("elem%0d_accept", i), 64'(acc), 64'd1);
    end
  endtask

  task automatic finish_fold(input int hold, input bit last);
    int g = 0;
    while (!cur_fold_valid() && g < 100) begin step(); g++; end
    check("fold_valid_seen", 64'(cur_fold_valid()), 64'd1);
    repeat (hold) step();
    done = 1'b1;
    step();
    done = 1'b0;
    check("fold_valid_drop", 64'(cur_fold_valid()), 64'd0);
    check("tile_done_after_done", 64'(cur_tile_done()), 64'(last));
    if (last) begin
      step();
      check("tile_done_single", 64'(cur_tile_done()), 64'd0);
      check("bm_ready_after_tile", 64'(cur_bm_ready()), 64'd1);
    end else begin
      check("next_fold_ele_ready", 64'(cur_ele_ready()), 64'd1);
    end
  endtask

  task automatic load_t1_coords();
    int r1[11] = '{0, 0, 0, 0, 2, 2, 2, 3, 3, 3, 3};
    int c1[11] = '{2, 3, 5, 6, 2, 5, 7, 2, 3, 5, 7};
    for (int k = 0; k < 32; k++) begin crow[k] = '0; ccol[k] = '0; end
    for (int k = 0; k < 11; k++) begin crow[k] = 2'(r1[k]); ccol[k] = 3'(c1[k]); end
  endtask

  task automatic load_d1();
    logic [31:0] d1[11] = '{32'hABCD_1234, 32'h5678_ABCD, 32'h0000_0001, 32'hFFFF_FFFF,
                           32'h8000_0000, 32'h1357_9BDF, 32'h2468_ACE0, 32'hDEAD_BEEF,
                           32'hCAFE_F00D, 32'h0F0F_0F0F, 32'h7FFF_FFFE};
    for (int k = 0; k < 32; k++) dat[k] = '0;
    for (int k = 0; k < 11; k++) dat[k] = d1[k];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state of both loaders.
    repeat (3) @(posedge clk);
    #1;
    check("rst_bm_ready_a", 64'(if_a.bm_ready), 64'd1);
    check("rst_outputs_a", 64'({if_a.fold_valid, if_a.ele_ready, if_a.tile_done, if_a.fold_count}), 64'd0);
    check("rst_mask_a", 64'(if_a.pe_mask), 64'd0);
    check("rst_bm_ready_b", 64'(if_b.bm_ready), 64'd1);
    check("rst_outputs_b", 64'({if_b.fold_valid, if_b.ele_ready, if_b.tile_done, if_b.pe_mask}), 64'd0);
    rst = 1'b0;
    step();

    // Sparse tile fits in one fold of 32 slots.
    load_t1_coords();
    load_d1();
    push_fold(0, 0, 11, 0);
    send_bm(T1_BM);
    send_elems(0, 11, 1'b0);
    check("t1_last_to_fold_valid", 64'(if_a.fold_valid), 64'd1);
    finish_fold(2, 1'b1);

    // Same tile on the 8-slot loader splits into folds of 8 and 3.
    sel = 1'b1;
    push_fold(1, 0, 8, 0);
    push_fold(1, 8, 3, 1);
    send_bm(T1_BM);
    send_elems(0, 8, 1'b0);
    check("t2_full_fold_valid", 64'(if_b.fold_valid), 64'd1);
    check("t2_full_ele_ready", 64'(if_b.ele_ready), 64'd0);
    finish_fold(1, 1'b0);
    send_elems(8, 3, 1'b0);
    check("t2_fold1_valid", 64'(if_b.fold_valid), 64'd1);
    finish_fold(1, 1'b1);
    sel = 1'b0;

    // Empty tile: straight to cleanup, no fold.
    send_bm(32'h0);
    repeat (3) step();

    // Bursty element stream, done pulsed during LOAD, consumer stalls 20 cycles.
    for (int k = 0; k < 11; k++) dat[k] = 32'(k) * 32'h0101_0101 + 32'h0000_00A5;
    push_fold(0, 0, 11, 0);
    send_bm(T1_BM);
    done = 1'b1;
    step();
    done = 1'b0;
    check("t4_load_ignores_done", 64'(if_a.ele_ready), 64'd1);
    send_elems(0, 11, 1'b1);
    check("t4_fold_valid", 64'(if_a.fold_valid), 64'd1);
    finish_fold(20, 1'b1);

    // Reset mid-load discards the partial fold.
    load_d1();
    send_bm(T1_BM);
    send_elems(0, 5, 1'b0);
    rst = 1'b1;
    step();
    check("t5_bm_ready", 64'(if_a.bm_ready), 64'd1);
    check("t5_pe_mask", 64'(if_a.pe_mask), 64'd0);
    check("t5_fold_count", 64'(if_a.fold_count), 64'd0);
    check("t5_ele_ready", 64'(if_a.ele_ready), 64'd0);
    rst = 1'b0;

    // Fresh, fully dense tile fills every slot.
    for (int k = 0; k < 32; k++) begin
      crow[k] = 2'(k / 8);
      ccol[k] = 3'(k % 8);
      dat[k]  = 32'hC0DE_0000 + 32'(k);
    end
    push_fold(0, 0, 32, 0);
    send_bm(32'hFFFF_FFFF);
    send_elems(0, 32, 1'b0);
    check("t6_fold_valid", 64'(if_a.fold_valid), 64'd1);
    check("t6_ele_ready_drop", 64'(if_a.ele_ready), 64'd0);
    finish_fold(1, 1'b1);

    repeat (2) step();
    check("queue_a_drained", 64'(qa.size()), 64'd0);
    check("queue_b_drained", 64'(qb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
